// File: rtl/md_pad_scanner_pkg.sv
// Shared definitions for the DB9 pad scanner and the joystick protocol block:
// FSM state encoding, pad type codes and bit positions of the joystick words.
// Optional feature macro: MD6BTN_EN (adds phases P4..P7 and 6-button decode).
package md_pad_scanner_pkg;

  typedef enum logic [3:0] {
    IDLE,
    P0, P1, P2, P3,
    P4, P5, P6, P7
  } state_t;

`ifdef MD6BTN_EN
  localparam state_t LAST_PHASE = P7;
`else
  localparam state_t LAST_PHASE = P3;
`endif

  typedef logic [1:0] pad_type_t;
  localparam pad_type_t PAD_NONE = 2'd0;
  localparam pad_type_t PAD_MD3  = 2'd1;
  localparam pad_type_t PAD_MD6  = 2'd2;

  // {F2,F1,U,D,L,R}; F2/F1 are also pin9/pin6 on the raw port
  localparam int JOY_R  = 0;
  localparam int JOY_L  = 1;
  localparam int JOY_D  = 2;
  localparam int JOY_U  = 3;
  localparam int JOY_F1 = 4;
  localparam int JOY_F2 = 5;

  // {Start,A,X,Y,Z,Mode}
  localparam int EXT_MODE  = 0;
  localparam int EXT_Z     = 1;
  localparam int EXT_Y     = 2;
  localparam int EXT_X     = 3;
  localparam int EXT_A     = 4;
  localparam int EXT_START = 5;

  // Select pin level while in a given state: low only in even phases
  function automatic logic sel_level(state_t s);
    case (s)
      P0, P2, P4, P6: return 1'b0;
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/md_pad_scanner_if.sv
// DB9 port bundle: raw pins in, select drive and decoded pad words out.
// master = scanner side, slave = pad / consumer side.
interface md_pad_scanner_if;
  logic [5:0] db9_in;
  logic       joy_sel;
  logic [5:0] joy_out;
  logic [5:0] joy_ext;
  logic [1:0] pad_type;
  logic       upd;

  modport master (input db9_in, output joy_sel, joy_out, joy_ext, pad_type, upd);
  modport slave  (output db9_in, input joy_sel, joy_out, joy_ext, pad_type, upd);
endinterface

// File: rtl/md_pad_scanner_db9_sync.sv
// Two-flop synchronizer for the six raw DB9 pins; resets to all-ones
// (released level of the pull-ups).
module db9_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] meta;

  // two-stage metastability filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/md_pad_scanner.sv
// DB9 joystick scanner: drives select, walks IDLE/P0..Pn, samples the pad in
// fixed phases and publishes {F2,F1,U,D,L,R}, extended buttons and pad type
// atomically at scan end with a one-cycle upd strobe.
// Optional feature macro: MD6BTN_EN (full P0..P7 sequence, 6-button decode).
module md_pad_scanner
  import md_pad_scanner_pkg::*;
#(
  parameter int PHASE_CYCLES = 280,
  parameter int IDLE_CYCLES  = 56000
) (
  input logic               clk,
  input logic               rst,
  md_pad_scanner_if.master  bus
);

  localparam int PW = $clog2(PHASE_CYCLES);
  localparam int IW = $clog2(IDLE_CYCLES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);

  logic [5:0] pins;

  db9_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.db9_in),
    .q   (pins)
  );

  state_t        state, state_n;
  logic [PW-1:0] phase_cnt, phase_cnt_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          sel;
  logic          phase_end;
  logic          scan_done;

  // state, counters and registered select drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      idle_cnt  <= '0;
      sel       <= 1'b1;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_cnt_n;
      idle_cnt  <= idle_cnt_n;
      sel       <= sel_level(state_n);
    end
  end

  // next state: idle countdown, then fixed-length phases up to LAST_PHASE
  always_comb begin
    state_n     = state;
    phase_cnt_n = phase_cnt;
    idle_cnt_n  = idle_cnt;
    phase_end   = 1'b0;
    scan_done   = 1'b0;
    if (state == IDLE) begin
      if (idle_cnt == IDLE_LAST) begin
        idle_cnt_n  = '0;
        phase_cnt_n = '0;
        state_n     = P0;
      end else begin
        idle_cnt_n = idle_cnt + 1'b1;
      end
    end else begin
      if (phase_cnt == PHASE_LAST) begin
        phase_cnt_n = '0;
        phase_end   = 1'b1;
        if (state == LAST_PHASE) begin
          state_n   = IDLE;
          scan_done = 1'b1;
        end else begin
          state_n = state_t'(state + 4'd1);
        end
      end else begin
        phase_cnt_n = phase_cnt + 1'b1;
      end
    end
  end

  logic [5:0] smp_p1;
  logic       smp_start;
  logic       smp_a;
  logic       smp_md;
  logic       smp_six;
  logic [3:0] smp_xyzm;

  // phase samples; always fully rewritten before the scan that uses them ends
  always_ff @(posedge clk) begin
    if (phase_end) begin
      case (state)
        P1: smp_p1 <= pins;
        P2: begin
          smp_start <= pins[JOY_F2];
          smp_a     <= pins[JOY_F1];
          smp_md    <= ~pins[JOY_L] & ~pins[JOY_R];
        end
`ifdef MD6BTN_EN
        P4: smp_six  <= ~|pins[JOY_U:JOY_R];
        P5: smp_xyzm <= {pins[JOY_L], pins[JOY_D], pins[JOY_U], pins[JOY_R]};
`endif
        default: ;
      endcase
    end
  end

`ifndef MD6BTN_EN
  assign smp_six  = 1'b0;
  assign smp_xyzm = 4'hF;
`endif

  logic [5:0] dec_out;
  logic [5:0] dec_ext;
  pad_type_t  dec_type;

  // pad classification from the scan's samples
  always_comb begin
    dec_out  = smp_p1;
    dec_ext  = '1;
    dec_type = PAD_NONE;
    if (smp_md) begin
      dec_ext[EXT_START] = smp_start;
      dec_ext[EXT_A]     = smp_a;
      dec_type           = PAD_MD3;
      if (smp_six) begin
        dec_ext[EXT_X]    = smp_xyzm[3];
        dec_ext[EXT_Y]    = smp_xyzm[2];
        dec_ext[EXT_Z]    = smp_xyzm[1];
        dec_ext[EXT_MODE] = smp_xyzm[0];
        dec_type          = PAD_MD6;
      end
    end
  end

  logic [5:0] joy_out_q;
  logic [5:0] joy_ext_q;
  pad_type_t  pad_type_q;
  logic       upd_q;

  // atomic publish of all outputs at scan end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      joy_out_q  <= 6'h3F;
      joy_ext_q  <= 6'h3F;
      pad_type_q <= PAD_NONE;
      upd_q      <= 1'b0;
    end else begin
      upd_q <= scan_done;
      if (scan_done) begin
        joy_out_q  <= dec_out;
        joy_ext_q  <= dec_ext;
        pad_type_q <= dec_type;
      end
    end
  end

  assign bus.joy_sel  = sel;
  assign bus.joy_out  = joy_out_q;
  assign bus.joy_ext  = joy_ext_q;
  assign bus.pad_type = pad_type_q;
  assign bus.upd      = upd_q;

endmodule
